bitwise_logic_pipe: RTL



---
 rtl/bitwise_logic_pipe_if.sv | 27 ++
 rtl/bitwise_logic_pipe.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_pipe_if.sv
// Handshake bundle for bitwise_logic_pipe: operand beat on the input side,
// result beat plus reduction flags on the output side.
interface bitwise_logic_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_ones;
    logic             out_parity;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_ones, out_parity
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_ones, out_parity
    );
endinterface

// File: rtl/bitwise_logic_pipe.sv
// Two-stage pipelined bitwise logic unit: S1 captures operands, S2 holds the
// registered result and its reduction flags; valid/ready on both sides.
module bitwise_logic_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    bitwise_logic_pipe_if.slave  pipe_if,
    output logic [CNT_W-1:0]     op_count
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ANDN = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    function automatic logic [WIDTH-1:0] logic_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        case (op)
            OP_AND:  logic_op = a & b;
            OP_OR:   logic_op = a | b;
            OP_XOR:  logic_op = a ^ b;
            OP_NAND: logic_op = ~(a & b);
            OP_NOR:  logic_op = ~(a | b);
            OP_XNOR: logic_op = ~(a ^ b);
            OP_ANDN: logic_op = a & ~b;
            OP_PASS: logic_op = a;
            default: logic_op = a;
        endcase
    endfunction

    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        parity_of = ^v;
    endfunction

    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        is_zero = ~(|v);
    endfunction

    function automatic logic is_ones(input logic [WIDTH-1:0] v);
        is_ones = &v;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_ones_q, s2_ones_d;
    logic             s2_parity_q, s2_parity_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_load_s;
    logic             in_ready_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic [WIDTH-1:0] s1_result_s;

    // Stage advance decisions; in_ready never looks at in_valid.
    always_comb begin
        s2_load_s  = s1_valid_q && (!s2_valid_q || pipe_if.out_ready);
        in_ready_s = !s1_valid_q || !s2_valid_q || pipe_if.out_ready;
        in_fire_s  = pipe_if.in_valid && in_ready_s;
        out_fire_s = s2_valid_q && pipe_if.out_ready;
    end

    // S1 next state: a new beat wins over draining into S2.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (in_fire_s) begin
            s1_valid_d = 1'b1;
            s1_a_d     = pipe_if.in_a;
            s1_b_d     = pipe_if.in_b;
            s1_op_d    = pipe_if.in_op;
        end else if (s2_load_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // S2 next state: flags are taken from the same value that gets registered.
    always_comb begin
        s1_result_s = logic_op(s1_op_q, s1_a_q, s1_b_q);
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_zero_d   = s2_zero_q;
        s2_ones_d   = s2_ones_q;
        s2_parity_d = s2_parity_q;
        if (s2_load_s) begin
            s2_valid_d  = 1'b1;
            s2_result_d = s1_result_s;
            s2_zero_d   = is_zero(s1_result_s);
            s2_ones_d   = is_ones(s1_result_s);
            s2_parity_d = parity_of(s1_result_s);
        end else if (out_fire_s) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Completed-transfer counter, wraps naturally at its width.
    always_comb begin
        if (out_fire_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output-visible state with asynchronous reset; in-flight beats are discarded.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= {WIDTH{1'b0}};
            s2_zero_q   <= 1'b1;
            s2_ones_q   <= 1'b0;
            s2_parity_q <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_zero_q   <= s2_zero_d;
            s2_ones_q   <= s2_ones_d;
            s2_parity_q <= s2_parity_d;
            cnt_q       <= cnt_d;
        end
    end

    // S1 operand storage; only meaningful while s1_valid_q is set.
    always_ff @(posedge clock) begin
        s1_a_q  <= s1_a_d;
        s1_b_q  <= s1_b_d;
        s1_op_q <= s1_op_d;
    end

    assign pipe_if.in_ready   = in_ready_s;
    assign pipe_if.out_valid  = s2_valid_q;
    assign pipe_if.out_result = s2_result_q;
    assign pipe_if.out_zero   = s2_zero_q;
    assign pipe_if.out_ones   = s2_ones_q;
    assign pipe_if.out_parity = s2_parity_q;
    assign op_count           = cnt_q;

endmodule
